// File: rtl/assignment_4.sv
// assignment_4: cyclic GREEN -> YELLOW -> RED traffic-light sequencer driving a single pass flag.
// Optional macro ASSIGNMENT_4_STATE_OUT_EN adds a state_out debug port carrying the state register.
module assignment_4 #(
  parameter int GREEN_CYCLES  = 5,
  parameter int YELLOW_CYCLES = 2,
  parameter int RED_CYCLES    = 7
) (
  output logic       pass,
`ifdef ASSIGNMENT_4_STATE_OUT_EN
  output logic [1:0] state_out,
`endif
  input  logic       clk,
  input  logic       rst
);

  localparam int MAX_GY  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int MAX_DUR = (MAX_GY > RED_CYCLES) ? MAX_GY : RED_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_DUR) < 1) ? 1 : $clog2(MAX_DUR);

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    UNUSED = 2'd3
  } state_t;

  // Power-up values put the block at the start of GREEN with pass already high.
  state_t           state      = GREEN;
  logic [CNT_W-1:0] count      = CNT_ZERO;
  logic             pass_q     = 1'b1;
  state_t           state_next;
  logic [CNT_W-1:0] count_next;
  logic             pass_next;

  // State, dwell counter and pass flag registers; reset beats every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= GREEN;
      count  <= CNT_ZERO;
      pass_q <= 1'b1;
    end else begin
      state  <= state_next;
      count  <= count_next;
      pass_q <= pass_next;
    end
  end

  // Next-state logic: leave a state once its dwell counter reaches duration - 1.
  always_comb begin
    state_next = state;
    count_next = count + CNT_ONE;
    case (state)
      GREEN: begin
        if (count == GREEN_LAST) begin
          state_next = YELLOW;
          count_next = CNT_ZERO;
        end else begin
          state_next = GREEN;
          count_next = count + CNT_ONE;
        end
      end
      YELLOW: begin
        if (count == YELLOW_LAST) begin
          state_next = RED;
          count_next = CNT_ZERO;
        end else begin
          state_next = YELLOW;
          count_next = count + CNT_ONE;
        end
      end
      RED: begin
        if (count == RED_LAST) begin
          state_next = GREEN;
          count_next = CNT_ZERO;
        end else begin
          state_next = RED;
          count_next = count + CNT_ONE;
        end
      end
      default: begin
        // Illegal encoding recovers to a clean GREEN start.
        state_next = GREEN;
        count_next = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state so pass is itself a register.
  always_comb begin
    pass_next = 1'b1;
    case (state_next)
      RED:     pass_next = 1'b0;
      default: pass_next = 1'b1;
    endcase
  end

  assign pass = pass_q;

`ifdef ASSIGNMENT_4_STATE_OUT_EN
  assign state_out = state;
`endif

endmodule

// File: tb/tb_assignment_4.sv
// Scoreboard bench for assignment_4: default (5/2/7) and short (3/1/2) instances, position-in-period model.
module tb_assignment_4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pass_a;
  logic pass_b;
`ifdef ASSIGNMENT_4_STATE_OUT_EN
  logic [1:0] state_a;
  logic [1:0] state_b;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: each light is just a position within its period.
  int t_a = 0;
  int t_b = 0;
  localparam int GA = 5, YA = 2, RA = 7;
  localparam int GB = 3, YB = 1, RB = 2;

  bit         qa[$];
  bit         qb[$];
  logic [1:0] qsa[$];
  logic [1:0] qsb[$];

  always #5 clk = ~clk;

  assignment_4 dut_a (
    .pass(pass_a),
`ifdef ASSIGNMENT_4_STATE_OUT_EN
    .state_out(state_a),
`endif
    .clk(clk),
    .rst(rst)
  );

  assignment_4 #(.GREEN_CYCLES(GB), .YELLOW_CYCLES(YB), .RED_CYCLES(RB)) dut_b (
    .pass(pass_b),
`ifdef ASSIGNMENT_4_STATE_OUT_EN
    .state_out(state_b),
`endif
    .clk(clk),
    .rst(rst)
  );

  function automatic bit exp_pass(input int t, input int g, input int y);
    return (t < g + y);
  endfunction

  function automatic logic [1:0] exp_state(input int t, input int g, input int y);
    if (t < g) return 2'd0;
    else if (t < g + y) return 2'd1;
    else return 2'd2;
  endfunction

  task automatic step(input bit r);
    rst = r;
    @(posedge clk);
    if (r) begin
      t_a = 0;
      t_b = 0;
    end else begin
      t_a = (t_a + 1) % (GA + YA + RA);
      t_b = (t_b + 1) % (GB + YB + RB);
    end
    qa.push_back(exp_pass(t_a, GA, YA));
    qb.push_back(exp_pass(t_b, GB, YB));
    qsa.push_back(exp_state(t_a, GA, YA));
    qsb.push_back(exp_state(t_b, GB, YB));
    #2;
  endtask

  // Monitor: one output sample per edge, compared against the oldest expectation.
  always @(negedge clk) begin
    bit e;
    logic [1:0] es;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      vectors++;
      if (pass_a !== e) begin
        miscompares++;
        $display("FAIL pass_a t=%0t got=%b want=%b", $time, pass_a, e);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      vectors++;
      if (pass_b !== e) begin
        miscompares++;
        $display("FAIL pass_b t=%0t got=%b want=%b", $time, pass_b, e);
      end
    end
    if (qsa.size() > 0) begin
      es = qsa.pop_front();
`ifdef ASSIGNMENT_4_STATE_OUT_EN
      vectors++;
      if (state_a !== es) begin
        miscompares++;
        $display("FAIL state_a t=%0t got=%0d want=%0d", $time, state_a, es);
      end
`endif
    end
    if (qsb.size() > 0) begin
      es = qsb.pop_front();
`ifdef ASSIGNMENT_4_STATE_OUT_EN
      vectors++;
      if (state_b !== es) begin
        miscompares++;
        $display("FAIL state_b t=%0t got=%0d want=%0d", $time, state_b, es);
      end
`endif
    end
  end

  initial begin
    #1;
    vectors++;
    if (pass_a !== 1'b1 || pass_b !== 1'b1) begin
      miscompares++;
      $display("FAIL powerup got=%b%b want=11", pass_a, pass_b);
    end

    step(1'b1);
    repeat (14) step(1'b0);
    repeat (5) step(1'b0);
    step(1'b1);
    repeat (7) step(1'b0);
    repeat (2) step(1'b0);
    step(1'b1);
    repeat (3) step(1'b1);
    repeat (42) step(1'b0);
    repeat (400) step($urandom_range(0, 9) == 0);
    rst = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d/%0d want=0/0", qa.size(), qb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/assignment_4.md
# assignment_4

Cyclic traffic-light controller that sequences GREEN → YELLOW → RED → GREEN on fixed cycle counts. It drives a single `pass` flag: high when traffic may proceed (GREEN or YELLOW), low on RED. It is a leaf block driven by the system clock, with its own synchronous reset returning it to the start of GREEN.

## Interface
Parameters:
- `GREEN_CYCLES`, default 5: clock cycles spent in GREEN; must be ≥ 1.
- `YELLOW_CYCLES`, default 2: clock cycles spent in YELLOW; must be ≥ 1.
- `RED_CYCLES`, default 7: clock cycles spent in RED; must be ≥ 1.

Ports (instantiation order is `pass, clk, rst`):
- One clock; reset is synchronous and active-high.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `pass`  output  1  1 = GREEN or YELLOW; 0 = RED.

## Operation
- State register: GREEN, YELLOW, RED, 2-bit encoding. Dwell counter width is `$clog2` of the largest duration, minimum 1 bit.
- Power-up initial value is state GREEN with counter 0, so `pass` = 1 before the first reset edge.
- On a rising edge with `rst` = 1: state ← GREEN, counter ← 0. Reset has priority over every transition.
- On a rising edge without reset:
  - If counter == (duration of current state − 1), advance to the next state and clear the counter.
  - Otherwise increment the counter.
- Transitions: GREEN → YELLOW after `GREEN_CYCLES` edges; YELLOW → RED after `YELLOW_CYCLES` edges; RED → GREEN after `RED_CYCLES` edges; wraps indefinitely.
- `pass` = (state != RED). It is decoded from the state register only, with no combinational path from `rst`.
- Unused encoding (3): the next edge goes to GREEN with counter 0.

## Timing
- Edges are counted from the edge at which GREEN was entered, or the reset edge, as edge 0.
- With default parameters:
  - `pass` = 1 after edges 1..6 (GREEN through edge 4, YELLOW on edges 5–6).
  - `pass` = 0 after edges 7..13.
  - GREEN is re-entered at edge 14, giving a period of 14 cycles.
- Latency: a reset edge forces `pass` = 1 in the cycle immediately after that edge.
- Reset mid-sequence, in any state or count, discards all progress. The full GREEN + YELLOW interval restarts.
- Reset held for several cycles keeps the block in GREEN with counter 0.

## Configuration
- Macro `ASSIGNMENT_4_STATE_OUT_EN`.
- Defined: adds output port `state_out` [1:0] after `pass`, carrying the current state register (GREEN=0, YELLOW=1, RED=2) for debug and observation.
- Undefined: no extra port. Behaviour of `pass` is identical in both builds.

## Test plan
- Power-up then `rst`=1 for 1 edge → `pass`=1 before and after the reset edge.
- Release reset → `pass`=1 after edges 1–6, 0 after edges 7–13, 1 after edge 14.
- Reset asserted for one edge while 5 edges into GREEN/YELLOW (one short of RED) → after 6 further edges `pass`=1, after the 7th `pass`=0.
- Reset asserted during RED → `pass`=1 immediately after the reset edge; the full 7-cycle pass interval follows.
- Run 3 full periods (42 edges) → `pass` high-count 7 and low-count 7 per period, no glitches between edges.
- Non-default parameters (e.g. 3/1/2) → GREEN/YELLOW/RED dwell of exactly 3/1/2 edges. With the macro defined, `state_out` sequences 0,0,0,1,2,2,0.
